// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle
// mult/div freeze, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        md_op,
    input  logic        cnt_clr,
    output logic        PCwrite,
    output logic        IFIDwrite,
    output logic        Ctrl_IDEX_mux,
    output logic        IFIDflush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

    // Counter preload is N-1 so the busy phase covers cnt = N-1 .. 0.
    localparam logic [5:0] MULT_LD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LD  = 6'(DIV_CYCLES - 1);

    state_t     state, state_nxt;
    logic [5:0] md_cnt, md_cnt_nxt;
    logic       load_use;

    // Writes to $0 are discarded, so a load targeting $0 never creates a hazard.
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Outputs and next state; hazards act in the cycle they are seen.
    always_comb begin
        PCwrite       = 1'b0;
        IFIDwrite     = 1'b0;
        Ctrl_IDEX_mux = 1'b0;
        IFIDflush     = 1'b0;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        state_nxt     = state;
        md_cnt_nxt    = md_cnt;
        if (rst_n) begin
            case (state)
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (md_cnt == 6'd0) state_nxt = MD_DONE;
                    else                md_cnt_nxt = md_cnt - 6'd1;
                end
                default: begin
                    // RUN and MD_DONE share hazard handling; MD_DONE lasts one cycle.
                    PCwrite       = 1'b1;
                    IFIDwrite     = 1'b1;
                    Ctrl_IDEX_mux = 1'b1;
                    md_done       = (state == MD_DONE);
                    state_nxt     = RUN;
                    if (branch_taken) begin
                        IFIDflush     = 1'b1;
                        Ctrl_IDEX_mux = 1'b0;
                    end else if (load_use) begin
                        PCwrite       = 1'b0;
                        IFIDwrite     = 1'b0;
                        Ctrl_IDEX_mux = 1'b0;
                    end else if (md_start) begin
                        state_nxt  = MD_BUSY;
                        md_cnt_nxt = md_op ? DIV_LD : MULT_LD;
                    end
                end
            endcase
        end
    end

    // FSM state and freeze counter; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= 6'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Saturating stall counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     stall_cnt <= 16'd0;
        else if (cnt_clr)                               stall_cnt <= 16'd0;
        else if (!PCwrite && (stall_cnt != 16'hFFFF))   stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idex_memread, branch_taken, md_start, md_op, cnt_clr;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        PCwrite, IFIDwrite, Ctrl_IDEX_mux, IFIDflush, md_busy, md_done;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken), .md_start(md_start), .md_op(md_op),
        .cnt_clr(cnt_clr),
        .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .Ctrl_IDEX_mux(Ctrl_IDEX_mux),
        .IFIDflush(IFIDflush), .md_busy(md_busy), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; md_start = 0; md_op = 0; cnt_clr = 0;
    endtask

    // Packs the four pipeline-control outputs as {PCwrite,IFIDwrite,mux,flush}.
    function automatic logic [3:0] ctl();
        return {PCwrite, IFIDwrite, Ctrl_IDEX_mux, IFIDflush};
    endfunction

    int n;
    int seen_done;

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("rst_ctl", ctl(), 4'b0000);
        chk("rst_md", {md_busy, md_done}, 2'b00);
        chk("rst_cnt", stall_cnt, 16'd0);
        #10 rst_n = 1;
        #1;
        chk("run_dflt", ctl(), 4'b1110);
        chk("run_md", {md_busy, md_done}, 2'b00);

        // Load-use via rt
        cyc();
        idex_memread = 1; idex_rt = 5; ifid_rt = 5; #1;
        chk("lu_rt_ctl", ctl(), 4'b0000);
        cyc(); idle(); #1;
        chk("lu_rt_cnt", stall_cnt, 16'd1);
        chk("lu_rt_after", ctl(), 4'b1110);

        // Load to $0 never stalls
        idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; #1;
        chk("ld0_ctl", ctl(), 4'b1110);
        cyc(); idle(); #1;
        chk("ld0_cnt", stall_cnt, 16'd1);

        // Load-use via rs, then a non-matching load
        idex_memread = 1; idex_rt = 7; ifid_rs = 7; ifid_rt = 3; #1;
        chk("lu_rs_ctl", ctl(), 4'b0000);
        cyc();
        ifid_rs = 3; ifid_rt = 4; #1;
        chk("nomatch_ctl", ctl(), 4'b1110);
        cyc(); idle(); #1;
        chk("lu_rs_cnt", stall_cnt, 16'd2);

        // Clear
        cnt_clr = 1;
        cyc(); idle(); #1;
        chk("clr_cnt", stall_cnt, 16'd0);

        // Branch beats load-use and md_start
        branch_taken = 1; idex_memread = 1; idex_rt = 9; ifid_rs = 9; md_start = 1; md_op = 1; #1;
        chk("prio_ctl", ctl(), 4'b1101);
        cyc(); idle(); #1;
        chk("prio_state", {md_busy, md_done}, 2'b00);
        chk("prio_cnt", stall_cnt, 16'd0);

        // Load-use masks md_start
        idex_memread = 1; idex_rt = 9; ifid_rt = 9; md_start = 1; #1;
        chk("mask_ctl", ctl(), 4'b0000);
        cyc(); idle(); #1;
        chk("mask_busy", md_busy, 1'b0);
        chk("mask_cnt", stall_cnt, 16'd1);
        cnt_clr = 1; cyc(); idle(); #1;

        // Multiply: 4 busy cycles; branch during busy is ignored
        md_start = 1; md_op = 0; #1;
        chk("mul_acc_ctl", ctl(), 4'b1110);
        cyc(); idle(); branch_taken = 1; #1;
        n = 0;
        while (md_busy && n < 100) begin
            if (ctl() !== 4'b0000) chk("mul_busy_ctl", ctl(), 4'b0000);
            n++; cyc();
        end
        branch_taken = 0; #1;
        chk("mul_len", n, 4);
        chk("mul_done", {md_busy, md_done}, 2'b01);
        cyc(); #1;
        chk("mul_done_1cyc", md_done, 1'b0);
        chk("mul_cnt", stall_cnt, 16'd4);
        cnt_clr = 1; cyc(); idle(); #1;

        // Divide followed back-to-back by a multiply
        md_start = 1; md_op = 1; #1;
        cyc(); idle(); #1;
        n = 0;
        while (md_busy && n < 100) begin n++; cyc(); end
        chk("div_len", n, 32);
        chk("div_done", {md_busy, md_done, PCwrite}, 3'b011);
        chk("div_cnt", stall_cnt, 16'd32);
        md_start = 1; md_op = 0; #1;
        cyc(); idle(); #1;
        chk("b2b_busy", md_busy, 1'b1);
        n = 0;
        while (md_busy && n < 100) begin n++; cyc(); end
        chk("b2b_len", n, 4);
        chk("b2b_done", md_done, 1'b1);
        cyc(); #1;
        chk("b2b_cnt", stall_cnt, 16'd36);
        cnt_clr = 1; cyc(); idle(); #1;

        // Reset at cycle 10 of a divide
        md_start = 1; md_op = 1; #1;
        cyc(); idle(); #1;
        repeat (9) cyc();
        chk("mid_busy", md_busy, 1'b1);
        rst_n = 0; #1;
        chk("mid_rst_ctl", ctl(), 4'b0000);
        chk("mid_rst_md", {md_busy, md_done}, 2'b00);
        chk("mid_rst_cnt", stall_cnt, 16'd0);
        cyc();
        #2 rst_n = 1; #1;
        chk("post_rst_ctl", ctl(), 4'b1110);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_done || md_busy) seen_done++;
            cyc();
        end
        chk("post_rst_nodone", seen_done, 0);

        // Saturation, then clear alongside a stall
        idex_memread = 1; idex_rt = 5; ifid_rt = 5; #1;
        repeat (65540) cyc();
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        cnt_clr = 1;
        cyc(); #1;
        chk("clr_vs_inc", stall_cnt, 16'd0);
        cnt_clr = 0;
        cyc(); idle(); #1;
        chk("inc_after_clr", stall_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
